// File: rtl/sync_fifo_gen2_if.sv
// Bus bundle for sync_fifo_gen2: producer/consumer handshake, thresholds and status.
// master = the block driving the FIFO, slave = the FIFO itself.
interface sync_fifo_gen2_if #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 8
);
  localparam int CW = $clog2(DEPTH + 1);

  logic              flush;
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              rd_en;
  logic [CW-1:0]     af_thresh;
  logic [CW-1:0]     ae_thresh;
  logic              clr_sticky;

  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              wr_ack;
  logic              overflow;
  logic              underflow;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic [CW-1:0]     level;
  logic              ovf_sticky;
  logic              udf_sticky;
  logic [CW-1:0]     hwm;

  modport master (
    output flush, wr_en, wr_data, rd_en, af_thresh, ae_thresh, clr_sticky,
    input  rd_data, rd_valid, wr_ack, overflow, underflow, full, empty,
           almost_full, almost_empty, level, ovf_sticky, udf_sticky, hwm
  );

  modport slave (
    input  flush, wr_en, wr_data, rd_en, af_thresh, ae_thresh, clr_sticky,
    output rd_data, rd_valid, wr_ack, overflow, underflow, full, empty,
           almost_full, almost_empty, level, ovf_sticky, udf_sticky, hwm
  );
endinterface

// File: rtl/sync_fifo_gen2.sv
// Single-clock FIFO with arbitrary depth, standard or FWFT read, live thresholds,
// write-through when full, flush and sticky errors. Define FIFO_HWM_EN for high-water-mark tracking.
module sync_fifo_gen2 #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 8,
  parameter int FWFT   = 0,
  parameter int CW     = $clog2(DEPTH + 1)
) (
  input logic           clk,
  input logic           rst_n,
  sync_fifo_gen2_if.slave bus
);

  localparam int            PW      = $clog2(DEPTH);
  localparam logic [PW-1:0] LAST    = PW'(DEPTH - 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     level_q;
  logic [CW-1:0]     level_next;
  logic              full_c;
  logic              empty_c;
  logic              rd_acc;
  logic              wr_acc;
  logic              ovf_evt;
  logic              udf_evt;
  logic              wr_ack_q;
  logic              overflow_q;
  logic              underflow_q;
  logic              ovf_sticky_q;
  logic              udf_sticky_q;

  // Explicit wrap so non-power-of-two depths never index past the last slot.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + PW'(1);
  endfunction

  assign full_c  = (level_q == DEPTH_C);
  assign empty_c = (level_q == '0);
  assign rd_acc  = bus.rd_en & ~empty_c;
  assign wr_acc  = bus.wr_en & (~full_c | rd_acc);
  assign ovf_evt = ~bus.flush & bus.wr_en & ~wr_acc;
  assign udf_evt = ~bus.flush & bus.rd_en & empty_c;

  // NOTE: every output of an always_comb gets a default first so no latch is inferred.
  always_comb begin
    level_next = level_q;
    if (bus.flush)
      level_next = '0;
    else if (wr_acc && !rd_acc)
      level_next = level_q + CW'(1);
    else if (rd_acc && !wr_acc)
      level_next = level_q - CW'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else if (bus.flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (wr_acc) wr_ptr <= ptr_inc(wr_ptr);
      if (rd_acc) rd_ptr <= ptr_inc(rd_ptr);
      level_q <= level_next;
    end
  end

  // NOTE: storage has no reset so it can map onto RAM; validity is tracked by level alone.
  always_ff @(posedge clk) begin
    if (rst_n && !bus.flush && wr_acc)
      mem[wr_ptr] <= bus.wr_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ack_q     <= 1'b0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
      ovf_sticky_q <= 1'b0;
      udf_sticky_q <= 1'b0;
    end else begin
      wr_ack_q    <= ~bus.flush & wr_acc;
      overflow_q  <= ovf_evt;
      underflow_q <= udf_evt;
      // A new error in the clearing cycle must not be lost, so set beats clear.
      if (ovf_evt)             ovf_sticky_q <= 1'b1;
      else if (bus.clr_sticky) ovf_sticky_q <= 1'b0;
      if (udf_evt)             udf_sticky_q <= 1'b1;
      else if (bus.clr_sticky) udf_sticky_q <= 1'b0;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head word is presented directly; masked while empty so idle output is a clean zero.
      assign bus.rd_data  = empty_c ? '0 : mem[rd_ptr];
      assign bus.rd_valid = ~empty_c;
    end else begin : g_std
      logic [DATA_W-1:0] rd_data_q;
      logic              rd_valid_q;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          rd_data_q  <= '0;
          rd_valid_q <= 1'b0;
        end else if (bus.flush) begin
          rd_valid_q <= 1'b0;
        end else if (rd_acc) begin
          rd_data_q  <= mem[rd_ptr];
          rd_valid_q <= 1'b1;
        end else begin
          rd_valid_q <= 1'b0;
        end
      end

      assign bus.rd_data  = rd_data_q;
      assign bus.rd_valid = rd_valid_q;
    end
  endgenerate

`ifdef FIFO_HWM_EN
  logic [CW-1:0] hwm_q;

  // level_next is zero during flush, so the max leaves the mark untouched there.
  always_ff @(posedge clk) begin
    if (!rst_n)
      hwm_q <= '0;
    else if (bus.clr_sticky)
      hwm_q <= level_next;
    else if (level_next > hwm_q)
      hwm_q <= level_next;
  end

  assign bus.hwm = hwm_q;
`else
  assign bus.hwm = '0;
`endif

  assign bus.wr_ack       = wr_ack_q;
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;
  assign bus.ovf_sticky   = ovf_sticky_q;
  assign bus.udf_sticky   = udf_sticky_q;
  assign bus.full         = full_c;
  assign bus.empty        = empty_c;
  assign bus.level        = level_q;
  assign bus.almost_full  = (bus.af_thresh != '0) & (level_q >= bus.af_thresh);
  assign bus.almost_empty = (level_q <= bus.ae_thresh);

  // Structural invariants; simulation only, ignored by synthesis.
  a_level_bound: assert property (@(posedge clk) disable iff (!rst_n) level_q <= DEPTH_C);
  a_wr_ptr_bound: assert property (@(posedge clk) disable iff (!rst_n) wr_ptr <= LAST);
  a_rd_ptr_bound: assert property (@(posedge clk) disable iff (!rst_n) rd_ptr <= LAST);

endmodule

// File: tb/tb_sync_fifo_gen2.sv
// Directed bench for sync_fifo_gen2: standard DEPTH=8, standard DEPTH=5 (wrap) and FWFT DEPTH=8 instances.
module tb_sync_fifo_gen2;

`ifdef FIFO_HWM_EN
  localparam bit HWM_EN = 1'b1;
`else
  localparam bit HWM_EN = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   vectors    = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  sync_fifo_gen2_if #(.DATA_W(16), .DEPTH(8)) s_if ();
  sync_fifo_gen2_if #(.DATA_W(16), .DEPTH(5)) w_if ();
  sync_fifo_gen2_if #(.DATA_W(16), .DEPTH(8)) f_if ();

  sync_fifo_gen2 #(.DATA_W(16), .DEPTH(8), .FWFT(0)) u_std  (.clk(clk), .rst_n(rst_n), .bus(s_if));
  sync_fifo_gen2 #(.DATA_W(16), .DEPTH(5), .FWFT(0)) u_wrap (.clk(clk), .rst_n(rst_n), .bus(w_if));
  sync_fifo_gen2 #(.DATA_W(16), .DEPTH(8), .FWFT(1)) u_fwft (.clk(clk), .rst_n(rst_n), .bus(f_if));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    s_if.flush = 0; s_if.wr_en = 0; s_if.wr_data = '0; s_if.rd_en = 0; s_if.clr_sticky = 0;
    s_if.af_thresh = 4'd6; s_if.ae_thresh = 4'd1;
    w_if.flush = 0; w_if.wr_en = 0; w_if.wr_data = '0; w_if.rd_en = 0; w_if.clr_sticky = 0;
    w_if.af_thresh = 3'd4; w_if.ae_thresh = 3'd1;
    f_if.flush = 0; f_if.wr_en = 0; f_if.wr_data = '0; f_if.rd_en = 0; f_if.clr_sticky = 0;
    f_if.af_thresh = 4'd6; f_if.ae_thresh = 4'd1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    vectors++; if (s_if.level !== 4'd0) begin miscompares++; $display("FAIL reset_level got %0d want 0", s_if.level); end
    vectors++; if (s_if.empty !== 1'b1) begin miscompares++; $display("FAIL reset_empty got %b want 1", s_if.empty); end
    vectors++; if (s_if.almost_empty !== 1'b1) begin miscompares++; $display("FAIL reset_almost_empty got %b want 1", s_if.almost_empty); end
    vectors++; if (s_if.full !== 1'b0) begin miscompares++; $display("FAIL reset_full got %b want 0", s_if.full); end
    vectors++; if (s_if.almost_full !== 1'b0) begin miscompares++; $display("FAIL reset_almost_full got %b want 0", s_if.almost_full); end
    vectors++; if (s_if.rd_data !== 16'h0000) begin miscompares++; $display("FAIL reset_rd_data got %h want 0000", s_if.rd_data); end
    vectors++; if (s_if.rd_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rd_valid got %b want 0", s_if.rd_valid); end
    vectors++; if ({s_if.wr_ack, s_if.overflow, s_if.underflow} !== 3'b000) begin miscompares++; $display("FAIL reset_pulses got %b want 000", {s_if.wr_ack, s_if.overflow, s_if.underflow}); end
    vectors++; if ({s_if.ovf_sticky, s_if.udf_sticky} !== 2'b00) begin miscompares++; $display("FAIL reset_sticky got %b want 00", {s_if.ovf_sticky, s_if.udf_sticky}); end
    vectors++; if (s_if.hwm !== 4'd0) begin miscompares++; $display("FAIL reset_hwm got %0d want 0", s_if.hwm); end
    vectors++; if (f_if.rd_valid !== 1'b0) begin miscompares++; $display("FAIL reset_fwft_rd_valid got %b want 0", f_if.rd_valid); end
    vectors++; if (w_if.empty !== 1'b1) begin miscompares++; $display("FAIL reset_wrap_empty got %b want 1", w_if.empty); end
  endtask

  task automatic test_fill();
    for (int i = 1; i <= 8; i++) begin
      s_if.wr_en = 1'b1;
      s_if.wr_data = 16'(i);
      tick();
      vectors++; if (s_if.wr_ack !== 1'b1) begin miscompares++; $display("FAIL fill_wr_ack i=%0d got %b want 1", i, s_if.wr_ack); end
      vectors++; if (s_if.level !== 4'(i)) begin miscompares++; $display("FAIL fill_level got %0d want %0d", s_if.level, i); end
      vectors++; if (s_if.almost_full !== (i >= 6)) begin miscompares++; $display("FAIL fill_almost_full i=%0d got %b want %b", i, s_if.almost_full, (i >= 6)); end
      vectors++; if (s_if.full !== (i == 8)) begin miscompares++; $display("FAIL fill_full i=%0d got %b want %b", i, s_if.full, (i == 8)); end
      vectors++; if (s_if.almost_empty !== (i <= 1)) begin miscompares++; $display("FAIL fill_almost_empty i=%0d got %b want %b", i, s_if.almost_empty, (i <= 1)); end
    end
    s_if.wr_data = 16'h0099;
    tick();
    vectors++; if (s_if.overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_pulse got %b want 1", s_if.overflow); end
    vectors++; if (s_if.wr_ack !== 1'b0) begin miscompares++; $display("FAIL ovf_wr_ack got %b want 0", s_if.wr_ack); end
    vectors++; if (s_if.ovf_sticky !== 1'b1) begin miscompares++; $display("FAIL ovf_sticky got %b want 1", s_if.ovf_sticky); end
    vectors++; if (s_if.level !== 4'd8) begin miscompares++; $display("FAIL ovf_level got %0d want 8", s_if.level); end
    s_if.wr_en = 1'b0;
    tick();
    vectors++; if (s_if.overflow !== 1'b0) begin miscompares++; $display("FAIL ovf_one_cycle got %b want 0", s_if.overflow); end
    vectors++; if (s_if.ovf_sticky !== 1'b1) begin miscompares++; $display("FAIL ovf_sticky_hold got %b want 1", s_if.ovf_sticky); end
    vectors++; if (s_if.hwm !== (HWM_EN ? 4'd8 : 4'd0)) begin miscompares++; $display("FAIL hwm_full got %0d want %0d", s_if.hwm, (HWM_EN ? 8 : 0)); end
    // Thresholds are live: zero disables almost_full, DEPTH is the top boundary.
    s_if.af_thresh = 4'd0;
    #1;
    vectors++; if (s_if.almost_full !== 1'b0) begin miscompares++; $display("FAIL af_zero got %b want 0", s_if.almost_full); end
    s_if.af_thresh = 4'd8;
    #1;
    vectors++; if (s_if.almost_full !== 1'b1) begin miscompares++; $display("FAIL af_depth got %b want 1", s_if.almost_full); end
    s_if.ae_thresh = 4'd8;
    #1;
    vectors++; if (s_if.almost_empty !== 1'b1) begin miscompares++; $display("FAIL ae_depth got %b want 1", s_if.almost_empty); end
    s_if.af_thresh = 4'd6;
    s_if.ae_thresh = 4'd1;
  endtask

  task automatic test_write_through();
    logic [15:0] want;
    s_if.wr_en = 1'b1;
    s_if.rd_en = 1'b1;
    s_if.wr_data = 16'h00AA;
    tick();
    s_if.wr_en = 1'b0;
    vectors++; if (s_if.rd_data !== 16'h0001 || s_if.rd_valid !== 1'b1) begin miscompares++; $display("FAIL wt_rd_data got %h/%b want 0001/1", s_if.rd_data, s_if.rd_valid); end
    vectors++; if (s_if.level !== 4'd8) begin miscompares++; $display("FAIL wt_level got %0d want 8", s_if.level); end
    vectors++; if (s_if.wr_ack !== 1'b1 || s_if.overflow !== 1'b0) begin miscompares++; $display("FAIL wt_ack_ovf got %b%b want 10", s_if.wr_ack, s_if.overflow); end
    for (int i = 2; i <= 9; i++) begin
      want = (i == 9) ? 16'h00AA : 16'(i);
      tick();
      vectors++; if (s_if.rd_data !== want || s_if.rd_valid !== 1'b1) begin miscompares++; $display("FAIL wt_drain got %h/%b want %h/1", s_if.rd_data, s_if.rd_valid, want); end
    end
    vectors++; if (s_if.empty !== 1'b1 || s_if.level !== 4'd0) begin miscompares++; $display("FAIL wt_empty got %b/%0d want 1/0", s_if.empty, s_if.level); end
    tick();
    s_if.rd_en = 1'b0;
    vectors++; if (s_if.underflow !== 1'b1 || s_if.udf_sticky !== 1'b1) begin miscompares++; $display("FAIL udf got %b/%b want 1/1", s_if.underflow, s_if.udf_sticky); end
    vectors++; if (s_if.rd_valid !== 1'b0 || s_if.rd_data !== 16'h00AA) begin miscompares++; $display("FAIL udf_hold got %b/%h want 0/00aa", s_if.rd_valid, s_if.rd_data); end
    s_if.clr_sticky = 1'b1;
    tick();
    s_if.clr_sticky = 1'b0;
    vectors++; if ({s_if.ovf_sticky, s_if.udf_sticky} !== 2'b00) begin miscompares++; $display("FAIL clr_sticky got %b want 00", {s_if.ovf_sticky, s_if.udf_sticky}); end
    vectors++; if (s_if.hwm !== 4'd0) begin miscompares++; $display("FAIL clr_hwm got %0d want 0", s_if.hwm); end
  endtask

  task automatic test_wrap();
    int  model;
    int  rd_idx;
    int  wr_idx;
    bit  we;
    bit  re;
    model = 0; rd_idx = 0; wr_idx = 0;
    for (int c = 0; c < 17; c++) begin
      we = (c < 12);
      re = (c >= 5);
      w_if.wr_en = we;
      w_if.rd_en = re;
      w_if.wr_data = 16'h0100 + 16'(wr_idx);
      tick();
      if (we) wr_idx++;
      model = model + int'(we) - int'(re);
      vectors++; if (w_if.level !== 3'(model) || w_if.level > 3'd5) begin miscompares++; $display("FAIL wrap_level c=%0d got %0d want %0d", c, w_if.level, model); end
      if (re) begin
        vectors++; if (w_if.rd_data !== 16'h0100 + 16'(rd_idx) || w_if.rd_valid !== 1'b1) begin miscompares++; $display("FAIL wrap_data c=%0d got %h want %h", c, w_if.rd_data, 16'h0100 + 16'(rd_idx)); end
        rd_idx++;
      end
    end
    w_if.wr_en = 1'b0;
    w_if.rd_en = 1'b0;
  endtask

  task automatic test_fwft();
    f_if.wr_en = 1'b1;
    f_if.wr_data = 16'h1234;
    tick();
    f_if.wr_en = 1'b0;
    vectors++; if (f_if.rd_valid !== 1'b1 || f_if.rd_data !== 16'h1234) begin miscompares++; $display("FAIL fwft_show got %b/%h want 1/1234", f_if.rd_valid, f_if.rd_data); end
    f_if.rd_en = 1'b1;
    tick();
    vectors++; if (f_if.empty !== 1'b1 || f_if.rd_valid !== 1'b0 || f_if.underflow !== 1'b0) begin miscompares++; $display("FAIL fwft_pop got e%b v%b u%b want e1 v0 u0", f_if.empty, f_if.rd_valid, f_if.underflow); end
    tick();
    f_if.rd_en = 1'b0;
    vectors++; if (f_if.underflow !== 1'b1 || f_if.udf_sticky !== 1'b1) begin miscompares++; $display("FAIL fwft_udf got %b/%b want 1/1", f_if.underflow, f_if.udf_sticky); end
  endtask

  task automatic test_flush();
    s_if.rd_en = 1'b1;
    tick();
    s_if.rd_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      s_if.wr_en = 1'b1;
      s_if.wr_data = 16'h0010 + 16'(i);
      tick();
    end
    vectors++; if (s_if.level !== 4'd5) begin miscompares++; $display("FAIL flush_pre_level got %0d want 5", s_if.level); end
    s_if.flush = 1'b1;
    s_if.wr_data = 16'h0055;
    tick();
    s_if.flush = 1'b0;
    s_if.wr_en = 1'b0;
    vectors++; if (s_if.level !== 4'd0 || s_if.empty !== 1'b1) begin miscompares++; $display("FAIL flush_level got %0d/%b want 0/1", s_if.level, s_if.empty); end
    vectors++; if (s_if.wr_ack !== 1'b0 || s_if.overflow !== 1'b0 || s_if.rd_valid !== 1'b0) begin miscompares++; $display("FAIL flush_pulses got a%b o%b v%b want 000", s_if.wr_ack, s_if.overflow, s_if.rd_valid); end
    vectors++; if (s_if.udf_sticky !== 1'b1 || s_if.ovf_sticky !== 1'b0) begin miscompares++; $display("FAIL flush_sticky got u%b o%b want u1 o0", s_if.udf_sticky, s_if.ovf_sticky); end
    vectors++; if (s_if.rd_data !== 16'h00AA) begin miscompares++; $display("FAIL flush_rd_hold got %h want 00aa", s_if.rd_data); end
    vectors++; if (s_if.hwm !== (HWM_EN ? 4'd5 : 4'd0)) begin miscompares++; $display("FAIL flush_hwm got %0d want %0d", s_if.hwm, (HWM_EN ? 5 : 0)); end
    s_if.wr_en = 1'b1;
    s_if.wr_data = 16'h0077;
    tick();
    s_if.wr_en = 1'b0;
    s_if.rd_en = 1'b1;
    tick();
    s_if.rd_en = 1'b0;
    vectors++; if (s_if.rd_data !== 16'h0077 || s_if.rd_valid !== 1'b1 || s_if.level !== 4'd0) begin miscompares++; $display("FAIL post_flush got %h/%b/%0d want 0077/1/0", s_if.rd_data, s_if.rd_valid, s_if.level); end
  endtask

  task automatic test_reset_mid();
    for (int i = 1; i <= 3; i++) begin
      s_if.wr_en = 1'b1;
      s_if.wr_data = 16'h0030 + 16'(i);
      tick();
    end
    vectors++; if (s_if.level !== 4'd3) begin miscompares++; $display("FAIL mid_pre_level got %0d want 3", s_if.level); end
    rst_n = 1'b0;
    s_if.rd_en = 1'b1;
    s_if.wr_data = 16'h0099;
    tick();
    rst_n = 1'b1;
    s_if.wr_en = 1'b0;
    s_if.rd_en = 1'b0;
    vectors++; if (s_if.level !== 4'd0 || s_if.empty !== 1'b1 || s_if.almost_empty !== 1'b1) begin miscompares++; $display("FAIL mid_level got %0d e%b ae%b want 0 e1 ae1", s_if.level, s_if.empty, s_if.almost_empty); end
    vectors++; if (s_if.full !== 1'b0 || s_if.almost_full !== 1'b0) begin miscompares++; $display("FAIL mid_full got %b%b want 00", s_if.full, s_if.almost_full); end
    vectors++; if (s_if.rd_data !== 16'h0000 || s_if.rd_valid !== 1'b0) begin miscompares++; $display("FAIL mid_rd got %h/%b want 0000/0", s_if.rd_data, s_if.rd_valid); end
    vectors++; if ({s_if.wr_ack, s_if.overflow, s_if.underflow} !== 3'b000) begin miscompares++; $display("FAIL mid_pulses got %b want 000", {s_if.wr_ack, s_if.overflow, s_if.underflow}); end
    vectors++; if ({s_if.ovf_sticky, s_if.udf_sticky} !== 2'b00) begin miscompares++; $display("FAIL mid_sticky got %b want 00", {s_if.ovf_sticky, s_if.udf_sticky}); end
    vectors++; if (s_if.hwm !== 4'd0) begin miscompares++; $display("FAIL mid_hwm got %0d want 0", s_if.hwm); end
  endtask

  initial begin
    idle_all();
    test_reset();
    test_fill();
    test_write_through();
    test_wrap();
    test_fwft();
    test_flush();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sync_fifo_gen2.md
Name: sync_fifo_gen2

Overview:
- Parametrised synchronous FIFO. Successor to the single-clock FIFO used on the interface datapath.
- Adds the following over the previous generation:
  - non-power-of-two depth
  - selectable standard or first-word-fall-through (FWFT) read mode
  - runtime-programmable almost-full and almost-empty thresholds
  - write-through-when-full on a simultaneous read
  - synchronous flush and sticky error status
- Sits between a producer and a consumer block in the same clock domain.

Parameters:
- DATA_W, 16: width of a data word.
- DEPTH, 8: number of entries. Legal values are 2 to 1024; DEPTH need not be a power of two.
- FWFT, 0: 0 selects the standard registered read; 1 selects first-word-fall-through.
- CW, $clog2(DEPTH+1): width of the level and threshold buses. Derived; do not override.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset.
- flush  in  1  synchronous clear of FIFO contents.
- wr_en  in  1  write request.
- wr_data  in  DATA_W  write data.
- rd_en  in  1  read or pop request.
- af_thresh  in  CW  almost-full threshold.
- ae_thresh  in  CW  almost-empty threshold.
- clr_sticky  in  1  clears the sticky error flags (and the HWM when enabled).
- rd_data  out  DATA_W  read data.
- rd_valid  out  1  rd_data is valid.
- wr_ack  out  1  previous-cycle write was accepted.
- overflow  out  1  previous-cycle write was rejected.
- underflow  out  1  previous-cycle read was rejected.
- full  out  1  level == DEPTH.
- empty  out  1  level == 0.
- almost_full  out  1  threshold flag.
- almost_empty  out  1  threshold flag.
- level  out  CW  current occupancy.
- ovf_sticky  out  1  overflow has occurred since last clear.
- udf_sticky  out  1  underflow has occurred since last clear.
- hwm  out  CW  high-water mark of level.

Behaviour:
- Reset: rst_n is synchronous, active-low. While rst_n is low at a clock edge:
  - wr_ptr, rd_ptr, level, rd_data, rd_valid, wr_ack, overflow, underflow, ovf_sticky, udf_sticky and hwm all clear to 0.
  - Flags after reset: empty=1, almost_empty=1, full=0, almost_full=0.
  - Reset asserted mid-operation discards all contents; any access in that cycle is ignored.
- Accept rules:
  - rd_acc = rd_en & !empty.
  - wr_acc = wr_en & (!full | rd_acc). A write to a full FIFO is accepted when a read is accepted in the same cycle.
- Pointer wrap: each pointer increments on its accept and wraps from DEPTH-1 to 0 explicitly. There is no reliance on power-of-two wrap.
- Level:
  - level_next = level + wr_acc - rd_acc, applied only in those two cycles where exactly one of wr_acc/rd_acc is true.
  - Simultaneous accepts leave level unchanged, including when level is 0 or DEPTH.
- Status flags:
  - full, empty, almost_full and almost_empty are combinational from the level register.
  - almost_full = (af_thresh != 0) & (level >= af_thresh).
  - almost_empty = (level <= ae_thresh).
  - Thresholds are used live, not latched.
- Standard read mode (FWFT=0):
  - On rd_acc, rd_data <= mem[rd_ptr] and rd_valid <= 1, giving 1-cycle latency.
  - Otherwise rd_valid <= 0 and rd_data holds.
  - When full and both wr_acc and rd_acc occur, rd_data gets the old word and the new word is stored in the freed slot.
- FWFT read mode (FWFT=1):
  - rd_data = mem[rd_ptr] combinationally; rd_valid = !empty.
  - rd_en pops the head entry.
  - The first write into an empty FIFO is visible on rd_data the cycle after wr_acc.
- Registered per-cycle status:
  - wr_ack <= wr_acc.
  - overflow <= wr_en & !wr_acc.
  - underflow <= rd_en & empty.
- Sticky flags:
  - ovf_sticky and udf_sticky set on the same edge as their pulse and clear on clr_sticky.
  - If set and clear occur in the same cycle, set wins.
- Flush:
  - Has priority over rd_en and wr_en.
  - Clears pointers, level and rd_valid.
  - Forces wr_ack, overflow and underflow to 0 on that edge.
  - rd_data holds; sticky flags and hwm are not cleared.
- Memory is not reset.

Optional Feature:
- Macro: FIFO_HWM_EN.
- Defined:
  - hwm <= max(hwm, level_next) every cycle.
  - On clr_sticky, hwm <= level_next.
  - hwm is reset to 0 and is unaffected by flush.
- Undefined: hwm is tied to 0 and no tracking logic is synthesised.

Test Plan (DEPTH=8, DATA_W=16, af_thresh=6, ae_thresh=1 unless noted):
- Reset, then write 0x0001..0x0008 on consecutive cycles:
  - wr_ack high for 8 cycles; level reaches 8; full=1.
  - almost_full asserts when level=6.
  - A 9th write gives overflow=1 for one cycle, ovf_sticky=1 and wr_ack=0.
- From full, assert wr_en and rd_en together with wr_data=0x00AA:
  - Standard mode: rd_data=0x0001 the next cycle; level stays 8; wr_ack=1; overflow=0.
  - Subsequent reads end with 0x00AA.
- Wrap: with DEPTH=5, run 12 writes interleaved with reads:
  - Read order matches write order exactly across both pointer wraps.
  - Level never exceeds 5.
- FWFT=1, empty FIFO, write 0x1234:
  - The next cycle gives rd_valid=1 and rd_data=0x1234 with no rd_en.
  - rd_en then gives empty=1, and a following rd_en gives underflow=1.
- At level=5, assert flush together with wr_en:
  - The next cycle gives level=0, empty=1, wr_ack=0, rd_valid=0.
  - Sticky flags unchanged; with FIFO_HWM_EN, hwm=5.
- Assert rst_n low for 1 cycle at level=3 while issuing wr_en and rd_en:
  - All outputs match their reset values the following cycle.
  - level=0, empty=1, almost_empty=1.
